threshold_stream: RTL and testbench
===================================

// Module: threshold_stream
// PURPOSE
//  Parametrised successor to the two-pixel (even/odd) image datapath between image reader and writer.
//  Accepts PIX_PER_CLK RGB pixels per beat, applies a per-frame mode (pass, binary threshold,
//  inverse threshold, saturating brightness), and emits a framed output stream.
//  Tracks row/column position and emits start-of-frame, end-of-line and frame-done markers.
// PARAMETERS
//  PIX_PER_CLK  2    pixels per beat; IMG_WIDTH must be a multiple of it
//  DATA_W       8    bits per colour channel
//  IMG_WIDTH    768  pixels per line
//  IMG_HEIGHT   512  lines per frame
// PORTS
//  clk         in   1                   single clock, rising edge
//  reset       in   1                   synchronous, active-high
//  in_vsync    in   1                   frame-start strobe, one cycle
//  in_hsync    in   1                   beat valid
//  in_data     in   PIX_PER_CLK*3*DATA_W  pixel k at [k*3*DATA_W +: 3*DATA_W], order {R,G,B}
//  mode        in   2                   00 pass, 01 binary, 10 inverse binary, 11 brightness
//  threshold   in   DATA_W              threshold for modes 01/10, increment for mode 11
//  out_valid   out  1                   output beat valid
//  out_data    out  PIX_PER_CLK*3*DATA_W  processed pixels, same packing
//  out_sof     out  1                   with first beat of frame
//  out_eol     out  1                   with last beat of each line
//  frame_done  out  1                   one-cycle pulse after last beat of frame
//  frame_err   out  1                   one-cycle pulse when a frame is aborted
//  busy        out  1                   high in ACTIVE or while pipeline non-empty
//  white_count out  32                  only meaningful with THRESH_STATS_EN
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0, pipeline valid bits cleared. Reset mid-frame drops all data.
//  FSM: IDLE -(in_vsync)-> ACTIVE -(last beat accepted)-> IDLE.
//   In ACTIVE, in_vsync aborts the frame: pulse frame_err, clear counters, stay ACTIVE (new frame).
//   Beats already in the pipeline still drain, with out_sof/out_eol as computed.
//  in_vsync in IDLE latches mode and threshold (thr_q) and computes thr3 = 3*thr_q (DATA_W+2 bits).
//   Changes to mode/threshold mid-frame are ignored.
//  in_hsync is ignored in IDLE; in_hsync in the same cycle as in_vsync is ignored.
//  Counters: col counts beats 0..IMG_WIDTH/PIX_PER_CLK-1 then wraps, incrementing row.
//   The beat at col=last, row=IMG_HEIGHT-1 ends the frame.
//  Pipeline, 2 stages, fixed latency: an input beat at cycle N appears on out_valid at N+2.
//   No backpressure. Gaps in in_hsync produce gaps in out_valid.
//  Stage 1 computes sum = R+G+B per pixel (DATA_W+2 bits, unsigned).
//   It also computes per-channel ch+thr_q (DATA_W+1 bits).
//  Stage 2 selects the result per pixel:
//   00: pixel unchanged.
//   01: all channels = {DATA_W{1}} if sum > thr3, else 0. Equality gives 0.
//   10: inverse of 01.
//   11: each channel = min(ch+thr_q, 2^DATA_W-1), saturating.
//  out_sof travels with beat (row0,col0). out_eol travels with every col=last beat.
//  frame_done pulses the cycle after the final beat's out_valid. No frame_done on aborted frames.
//  out_data holds its last value when out_valid=0.
// CONFIGURATION
//  THRESH_STATS_EN defined:
//   - A 32-bit counter increments by the number of stage-2 pixels with sum > thr3 (any mode).
//   - The counter is cleared on accepted in_vsync.
//   - white_count loads the final count in the same cycle frame_done pulses, and holds until the next frame_done or reset.
//  THRESH_STATS_EN undefined: no counter logic; white_count tied to 0.
// TESTING
//  1. Reset, IMG 4x2, PIX_PER_CLK=2, mode 01, thr 90, pixel (100,90,80): sum 270=thr3 -> out 0.
//     Pixel (91,90,90) -> out 0xFF on all channels. out_valid 2 cycles after in_hsync.
//  2. Mode 11, thr 0x40, pixel (0xF0,0x10,0xC0) -> (0xFF,0x50,0xFF).
//  3. Full 4x2 frame, continuous beats:
//     - out_sof on beat 0; out_eol on beats 1 and 3.
//     - frame_done 1 cycle after beat 3 output; busy low after.
//  4. mode/threshold changed mid-frame -> output uses values latched at in_vsync.
//     in_hsync without preceding in_vsync -> no out_valid.
//  5. in_vsync at beat 2 of 4 -> frame_err pulse, counters restart.
//     Next 4 beats form a full frame with out_sof and frame_done.
//  6. reset asserted mid-frame with 2 beats in flight -> no out_valid next cycles, all outputs 0.
//     With THRESH_STATS_EN: 3 of 8 pixels above threshold -> white_count=3 at frame_done.

Source files
------------

// File: rtl/threshold_stream.sv
// threshold_stream
//   Framed RGB pixel datapath. It accepts PIX_PER_CLK pixels per beat and applies a
//   per-frame mode: pass, binary threshold, inverse threshold or saturating brightness.
//   It tracks the column and row of each beat and tags each output beat with
//   start-of-frame and end-of-line. It pulses frame_done after the last beat of a
//   frame and frame_err when a frame is aborted by a new in_vsync.
//   The pipeline has a fixed latency of 2 cycles and no backpressure.
//
// Optional feature macro: THRESH_STATS_EN
//   When defined, white_count holds the number of pixels with R+G+B > 3*thr in the
//   last completed frame. When undefined, white_count is tied to 0.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-high reset
//   in_vsync         frame-start strobe (abort if already in a frame)
//   in_hsync         input beat valid
//   in_data          PIX_PER_CLK pixels, pixel k at [k*3*DATA_W +: 3*DATA_W], {R,G,B}
//   mode, threshold  latched at frame start (in IDLE only)
//   out_valid/out_data/out_sof/out_eol   output beat and its markers
//   frame_done       pulse one cycle after the final output beat of a completed frame
//   frame_err        pulse when a frame is aborted
//   busy             frame in progress or beats still in flight
//   white_count      per-frame above-threshold pixel count (THRESH_STATS_EN)

// Per-pixel two-stage datapath. Stage 1 registers the channel sum and the
// channel+threshold adds. Stage 2 selects the result for the frame mode.
module threshold_lane #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_en1,
  input  logic                i_en2,
  input  logic [3*DATA_W-1:0] i_pix,
  input  logic [DATA_W-1:0]   i_thr,
  input  logic [DATA_W+1:0]   i_thr3,
  input  logic [1:0]          i_mode,
  output logic [3*DATA_W-1:0] o_pix,
  output logic                o_above
);
  localparam logic [DATA_W-1:0] MAXV = '1;

  logic [2:0][DATA_W-1:0] w_ch;
  logic [2:0][DATA_W-1:0] w_sat;
  logic [3*DATA_W-1:0]    w_res;
  logic [DATA_W+1:0]      r_sum;
  logic [2:0][DATA_W:0]   r_add;
  logic [3*DATA_W-1:0]    r_pix1;
  logic [3*DATA_W-1:0]    r_pix2;

  assign w_ch = i_pix;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum  <= '0;
      r_add  <= '0;
      r_pix1 <= '0;
    end else if (i_en1) begin
      r_sum  <= (DATA_W+2)'(w_ch[0]) + (DATA_W+2)'(w_ch[1]) + (DATA_W+2)'(w_ch[2]);
      for (int c = 0; c < 3; c++)
        r_add[c] <= {1'b0, w_ch[c]} + {1'b0, i_thr};
      r_pix1 <= i_pix;
    end
  end

  // Strictly greater: equality with 3*thr counts as dark.
  assign o_above = r_sum > i_thr3;

  always_comb begin
    w_sat = '0;
    for (int c = 0; c < 3; c++)
      w_sat[c] = r_add[c][DATA_W] ? MAXV : r_add[c][DATA_W-1:0];
    w_res = r_pix1;
    case (i_mode)
      2'b01:   w_res = o_above ? '1 : '0;
      2'b10:   w_res = o_above ? '0 : '1;
      2'b11:   w_res = w_sat;
      default: w_res = r_pix1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)      r_pix2 <= '0;
    else if (i_en2) r_pix2 <= w_res;
  end

  assign o_pix = r_pix2;
endmodule

module threshold_stream #(
  parameter int PIX_PER_CLK = 2,
  parameter int DATA_W      = 8,
  parameter int IMG_WIDTH   = 768,
  parameter int IMG_HEIGHT  = 512
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_vsync,
  input  logic                            in_hsync,
  input  logic [PIX_PER_CLK*3*DATA_W-1:0] in_data,
  input  logic [1:0]                      mode,
  input  logic [DATA_W-1:0]               threshold,
  output logic                            out_valid,
  output logic [PIX_PER_CLK*3*DATA_W-1:0] out_data,
  output logic                            out_sof,
  output logic                            out_eol,
  output logic                            frame_done,
  output logic                            frame_err,
  output logic                            busy,
  output logic [31:0]                     white_count
);
  localparam int STAGES = 2;
  localparam int BEATS  = IMG_WIDTH / PIX_PER_CLK;
  localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(BEATS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  // Per-beat markers that travel alongside the data.
  typedef struct packed {
    logic sof;
    logic eol;
    logic last;
  } tag_t;

  state_t              r_state, w_state_nxt;
  logic                w_start, w_abort, w_acc;
  logic                w_eol_pos, w_last_pos;
  logic [CW-1:0]       r_col;
  logic [RW-1:0]       r_row;
  logic [1:0]          r_mode;
  logic [DATA_W-1:0]   r_thr;
  logic [DATA_W+1:0]   r_thr3;
  logic [STAGES:1]     r_vld_pipe;
  tag_t                r_tag1, r_tag2;
  logic                r_frame_done, r_frame_err;
  logic [PIX_PER_CLK-1:0]                   w_above;
  logic [PIX_PER_CLK-1:0][3*DATA_W-1:0]     w_lane_out;

  assign w_eol_pos  = (r_col == COL_LAST);
  assign w_last_pos = w_eol_pos && (r_row == ROW_LAST);

  // A beat coinciding with in_vsync is dropped; in IDLE beats are ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_acc       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_vsync) begin
          w_start     = 1'b1;
          w_state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (in_vsync) begin
          w_abort = 1'b1;
        end else if (in_hsync) begin
          w_acc = 1'b1;
          if (w_last_pos) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Frame configuration is captured only at frame start; an abort keeps it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode <= '0;
      r_thr  <= '0;
      r_thr3 <= '0;
    end else if (w_start) begin
      r_mode <= mode;
      r_thr  <= threshold;
      r_thr3 <= ({2'b00, threshold} << 1) + {2'b00, threshold};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_start || w_abort) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (w_eol_pos) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_pipe   <= '0;
      r_tag1       <= '0;
      r_tag2       <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_vld_pipe   <= {r_vld_pipe[STAGES-1:1], w_acc};
      if (w_acc) begin
        r_tag1.sof  <= (r_col == '0) && (r_row == '0);
        r_tag1.eol  <= w_eol_pos;
        r_tag1.last <= w_last_pos;
      end
      // Markers are zero on non-valid output cycles.
      r_tag2       <= r_vld_pipe[1] ? r_tag1 : '0;
      r_frame_done <= r_vld_pipe[STAGES] && r_tag2.last;
      r_frame_err  <= w_abort;
    end
  end

  for (genvar k = 0; k < PIX_PER_CLK; k++) begin : g_lane
    threshold_lane #(.DATA_W(DATA_W)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .i_en1  (w_acc),
      .i_en2  (r_vld_pipe[1]),
      .i_pix  (in_data[k*3*DATA_W +: 3*DATA_W]),
      .i_thr  (r_thr),
      .i_thr3 (r_thr3),
      .i_mode (r_mode),
      .o_pix  (w_lane_out[k]),
      .o_above(w_above[k])
    );
  end

  assign out_valid  = r_vld_pipe[STAGES];
  assign out_data   = w_lane_out;
  assign out_sof    = r_tag2.sof;
  assign out_eol    = r_tag2.eol;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state == S_ACTIVE) || (|r_vld_pipe);

`ifdef THRESH_STATS_EN
  logic [31:0] w_nabove;
  logic [31:0] r_white_acc;
  logic [31:0] r_white_q;

  always_comb begin
    w_nabove = '0;
    for (int k = 0; k < PIX_PER_CLK; k++)
      w_nabove = w_nabove + 32'(w_above[k]);
  end

  // Pixels are counted as they enter stage 2. A frame start clears the
  // running count, and that clear takes priority over a same-cycle add.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_white_acc <= '0;
      r_white_q   <= '0;
    end else begin
      if (w_start || w_abort)  r_white_acc <= '0;
      else if (r_vld_pipe[1])  r_white_acc <= r_white_acc + w_nabove;
      if (r_vld_pipe[STAGES] && r_tag2.last) r_white_q <= r_white_acc;
    end
  end

  assign white_count = r_white_q;
`else
  logic w_unused_above;
  assign w_unused_above = ^w_above;
  assign white_count    = '0;
`endif
endmodule

// File: tb/tb_threshold_stream.sv
module tb_threshold_stream;
  localparam int P = 2, D = 8, W = 4, H = 2;
  localparam int BW = P*3*D, BEATS = W/P, NB = BEATS*H;

  logic          clk = 1'b0;
  logic          reset, in_vsync, in_hsync;
  logic [BW-1:0] in_data;
  logic [1:0]    mode;
  logic [D-1:0]  threshold;
  logic          out_valid, out_sof, out_eol, frame_done, frame_err, busy;
  logic [BW-1:0] out_data;
  logic [31:0]   white_count;

  always #5 clk = ~clk;

  threshold_stream #(.PIX_PER_CLK(P), .DATA_W(D), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .in_vsync(in_vsync), .in_hsync(in_hsync), .in_data(in_data),
    .mode(mode), .threshold(threshold), .out_valid(out_valid), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol), .frame_done(frame_done), .frame_err(frame_err),
    .busy(busy), .white_count(white_count)
  );

  // Expected output beat, due on the edge index 'due'.
  typedef struct {
    int            due;
    logic [BW-1:0] data;
    bit            sof;
    bit            eol;
    int            nab;
  } exp_t;

  exp_t          q[$];
  int            n_chk = 0, n_err = 0, e = 0;
  bit            m_act;
  int            m_beat, m_mode, m_thr;
  int            done_e = -1, err_e = -1;
  longint        acc, wexp;
  logic [BW-1:0] last_data;

  function automatic int sat(int x);
    return (x > 255) ? 255 : x;
  endfunction

  function automatic bit is_above(int t, logic [23:0] p);
    return (int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0])) > 3*t;
  endfunction

  function automatic logic [23:0] ref_pix(int m, int t, logic [23:0] p);
    int r, g, b;
    r = p[23:16]; g = p[15:8]; b = p[7:0];
    case (m)
      0:       return p;
      1:       return is_above(t, p) ? 24'hFFFFFF : 24'h000000;
      2:       return is_above(t, p) ? 24'h000000 : 24'hFFFFFF;
      default: return {8'(sat(r+t)), 8'(sat(g+t)), 8'(sat(b+t))};
    endcase
  endfunction

  function automatic logic [BW-1:0] rnd();
    logic [63:0] x;
    x = {$urandom, $urandom};
    return x[BW-1:0];
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] expv);
    n_chk++;
    assert (got === expv) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, expv, e);
    end
  endtask

  // Reference behaviour for one sampled clock edge.
  task automatic model(bit r, bit v, bit h, logic [BW-1:0] d);
    exp_t x;
    if (r) begin
      q.delete(); m_act = 0; m_beat = 0; done_e = -1; err_e = -1;
      acc = 0; wexp = 0; last_data = '0;
      return;
    end
    if (e == done_e) wexp = acc;
    foreach (q[i]) if (q[i].due == e) acc += q[i].nab;
    if (v) begin
      if (!m_act) begin
        m_act = 1; m_mode = mode; m_thr = threshold;
      end else begin
        err_e = e;
      end
      m_beat = 0;
      acc = 0;
    end else if (h && m_act) begin
      x.due = e + 1;
      x.nab = 0;
      for (int k = 0; k < P; k++) begin
        x.data[k*24 +: 24] = ref_pix(m_mode, m_thr, d[k*24 +: 24]);
        x.nab += int'(is_above(m_thr, d[k*24 +: 24]));
      end
      x.sof = (m_beat == 0);
      x.eol = (m_beat % BEATS) == BEATS - 1;
      q.push_back(x);
      if (m_beat == NB - 1) begin
        done_e = e + 2;
        m_act  = 0;
      end
      m_beat++;
    end
  endtask

  task automatic check_outs();
    int idx;
    idx = -1;
    while (q.size() > 0 && q[0].due < e) void'(q.pop_front());
    foreach (q[i]) if (q[i].due == e) idx = i;
    if (idx >= 0) begin
      chk("valid", out_valid, 1);
      chk("data", out_data, q[idx].data);
      chk("sof", out_sof, q[idx].sof);
      chk("eol", out_eol, q[idx].eol);
      last_data = q[idx].data;
    end else begin
      chk("valid", out_valid, 0);
      chk("hold", out_data, last_data);
      chk("sof", out_sof, 0);
      chk("eol", out_eol, 0);
    end
    chk("frame_done", frame_done, (e == done_e));
    chk("frame_err", frame_err, (e == err_e));
    chk("busy", busy, (m_act || q.size() > 0));
`ifdef THRESH_STATS_EN
    chk("white_count", white_count, wexp);
`else
    chk("white_count", white_count, 0);
`endif
  endtask

  task automatic step(bit r, bit v, bit h, logic [BW-1:0] d);
    reset = r; in_vsync = v; in_hsync = h; in_data = d;
    @(posedge clk);
    e++;
    model(r, v, h, d);
    @(negedge clk);
    check_outs();
  endtask

  initial begin
    mode = 2'b00; threshold = '0;
    repeat (3) step(1, 0, 0, '0);

    // Binary threshold: sum equal to 3*thr is dark, one above is white.
    mode = 2'b01; threshold = 8'd90;
    step(0, 1, 0, '0);
    step(0, 0, 1, {24'h5B5A5A, 24'h645A50});
    step(0, 0, 0, '0);
    chk("t1_lit_valid", out_valid, 1);
    chk("t1_lit_data", out_data, 48'hFFFFFF_000000);
    repeat (3) step(0, 0, 1, rnd());
    repeat (3) step(0, 0, 0, '0);

    // Saturating brightness.
    mode = 2'b11; threshold = 8'h40;
    step(0, 1, 0, '0);
    step(0, 0, 1, {24'hF010C0, 24'h0A0B0C});
    step(0, 0, 0, '0);
    chk("t2_lit_data", out_data, 48'hFF50FF_4A4B4C);
    repeat (3) step(0, 0, 1, rnd());
    repeat (3) step(0, 0, 0, '0);

    // Continuous full frame, then frame_done and busy dropping.
    mode = 2'b10; threshold = 8'd100;
    step(0, 1, 0, '0);
    repeat (4) step(0, 0, 1, rnd());
    step(0, 0, 0, '0);
    chk("t3_last_eol", out_eol, 1);
    step(0, 0, 0, '0);
    chk("t3_done", frame_done, 1);
    chk("t3_busy", busy, 0);

    // Mid-frame config changes ignored; beats in IDLE ignored.
    mode = 2'b01; threshold = 8'd100;
    step(0, 1, 0, '0);
    step(0, 0, 1, rnd());
    mode = 2'b00; threshold = 8'd3;
    repeat (3) step(0, 0, 1, rnd());
    repeat (3) step(0, 0, 1, rnd());
    step(0, 0, 0, '0);
    chk("t4_idle_valid", out_valid, 0);

    // Abort after 2 beats, then a complete frame.
    step(0, 1, 0, '0);
    repeat (2) step(0, 0, 1, rnd());
    step(0, 1, 0, '0);
    chk("t5_err", frame_err, 1);
    repeat (4) step(0, 0, 1, rnd());
    repeat (3) step(0, 0, 0, '0);

    // Reset with beats in flight.
    step(0, 1, 0, '0);
    repeat (2) step(0, 0, 1, rnd());
    step(1, 0, 1, rnd());
    chk("t6_valid", out_valid, 0);
    chk("t6_data", out_data, 0);
    repeat (2) step(0, 0, 0, '0);

    // Randomised frames with gaps, aborts and ignored config changes.
    for (int f = 0; f < 40; f++) begin
      mode = 2'($urandom_range(0, 3)); threshold = 8'($urandom_range(0, 255));
      step(0, 1, 1'($urandom_range(0, 1)), rnd());
      for (int s = 0; s < 60 && m_act; s++) begin
        mode = 2'($urandom_range(0, 3)); threshold = 8'($urandom_range(0, 255));
        step(0, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), rnd());
      end
      repeat ($urandom_range(0, 3)) step(0, 0, 1'($urandom_range(0, 1)), rnd());
    end
    repeat (4) step(0, 0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
